// File: rtl/flick_conditioner.sv
// rtl/flick_conditioner.sv - button synchronizer, debounce FSM and press counter for the flash bounder
// Optional post-release flick stretch is enabled by defining FLICK_HOLD_EN.
module flick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       flick,
    output logic       flick_pulse,
    output logic [7:0] press_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          sync_q1;
    logic          s;
    logic          press_acc;
    logic          release_done;
    logic          lvl_nxt;
    logic          flick_nxt;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        press_acc    = 1'b0;
        release_done = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = ARM_PRESS;
                    cnt_nxt   = '0;
                end
            end
            ARM_PRESS: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    press_acc = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nxt = ARM_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            ARM_RELEASE: begin
                if (s) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    release_done = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // flick is registered from the next-state level so it rises on the accepting edge itself
    assign lvl_nxt = (state_nxt == PRESSED) || (state_nxt == ARM_RELEASE);

`ifdef FLICK_HOLD_EN
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;

    always_comb begin
        hold_nxt = hold_cnt;
        if (release_done) begin
            hold_nxt = HW'(HOLD_CYCLES);
        end else if (hold_cnt != '0) begin
            hold_nxt = hold_cnt - 1'b1;
        end
    end

    assign flick_nxt = lvl_nxt | (hold_nxt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_nxt;
        end
    end
`else
    // a negative hold is never legal, so this term folds to 0 and flick is plain lvl
    assign flick_nxt = lvl_nxt | (HOLD_CYCLES < 0) | (release_done & 1'b0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1     <= 1'b0;
            s           <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            flick       <= 1'b0;
            flick_pulse <= 1'b0;
            press_count <= 8'd0;
        end else begin
            sync_q1     <= btn_in;
            s           <= sync_q1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            flick       <= flick_nxt;
            flick_pulse <= press_acc;
            if (press_acc) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_flick_conditioner.sv
// tb/tb_flick_conditioner.sv - scoreboard bench for flick_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=6)
module tb_flick_conditioner;

`ifdef FLICK_HOLD_EN
    localparam int HOLD_EXTRA = 6;
    localparam int REPRESS_FALLS = 0;
`else
    localparam int HOLD_EXTRA = 0;
    localparam int REPRESS_FALLS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       flick;
    logic       flick_pulse;
    logic [7:0] press_count;

    flick_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .flick       (flick),
        .flick_pulse (flick_pulse),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         pulse_seen = 0;
    int         flick_falls = 0;
    int         flick_rises = 0;
    logic       flick_prev = 1'b0;
    logic [7:0] model_count = 8'd0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    always @(negedge clk) begin
        if (flick_pulse === 1'b1) pulse_seen++;
        if (flick_prev === 1'b1 && flick === 1'b0) flick_falls++;
        if (flick_prev === 1'b0 && flick === 1'b1) flick_rises++;
        flick_prev = flick;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        btn_in = 1'b0;
        tick(2);
        rst = 1'b0;
        model_count = 8'd0;
        exp_q.delete();
    endtask

    task automatic push_press;
        model_count = model_count + 8'd1;
        exp_q.push_back(model_count);
    endtask

    task automatic pop_exp;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        else exp_v = 8'hxx;
    endtask

    task automatic press_and_check(input int high, input int low);
        int used;
        bit found;
        btn_in = 1'b1;
        push_press();
        found = 1'b0;
        used = 0;
        while (!found && used < 12) begin
            tick(1);
            used++;
            if (flick_pulse === 1'b1) found = 1'b1;
        end
        pop_exp();
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL press_pulse_timeout: no pulse within %0d cycles, required one", used);
        end else if (press_count !== exp_v) begin
            n_fail++;
            $display("FAIL press_count: got %0d, required %0d", press_count, exp_v);
        end
        if (high > used) tick(high - used);
        btn_in = 1'b0;
        tick(low);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn_in = 1'b1;
        tick(2);
        n_checks++;
        if (flick !== 1'b0) begin n_fail++; $display("FAIL reset_flick: got %b, required 0", flick); end
        n_checks++;
        if (flick_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b, required 0", flick_pulse); end
        n_checks++;
        if (press_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", press_count); end
        rst = 1'b0;
        model_count = 8'd0;
        exp_q.delete();
        tick(6);
        n_checks++;
        if (flick !== 1'b0) begin n_fail++; $display("FAIL reset_rise_early: got %b at edge 6, required 0", flick); end
        push_press();
        tick(1);
        n_checks++;
        if (flick !== 1'b1) begin n_fail++; $display("FAIL reset_rise: got %b at edge 7, required 1", flick); end
        pop_exp();
        n_checks++;
        if (flick_pulse !== 1'b1 || press_count !== exp_v) begin
            n_fail++;
            $display("FAIL reset_press: pulse=%b count=%0d, required pulse=1 count=%0d", flick_pulse, press_count, exp_v);
        end
        btn_in = 1'b0;
        tick(12 + HOLD_EXTRA);
        n_checks++;
        if (flick !== 1'b0) begin n_fail++; $display("FAIL reset_release: got %b, required 0", flick); end
    endtask

    task automatic test_clean_press;
        int p0;
        do_reset();
        p0 = pulse_seen;
        btn_in = 1'b1;
        push_press();
        tick(6);
        n_checks++;
        if (flick !== 1'b0) begin n_fail++; $display("FAIL press_early: got %b at edge 6, required 0", flick); end
        tick(1);
        n_checks++;
        if (flick !== 1'b1) begin n_fail++; $display("FAIL press_edge: got %b at edge 7, required 1", flick); end
        pop_exp();
        n_checks++;
        if (flick_pulse !== 1'b1 || press_count !== exp_v) begin
            n_fail++;
            $display("FAIL press_strobe: pulse=%b count=%0d, required pulse=1 count=%0d", flick_pulse, press_count, exp_v);
        end
        tick(1);
        n_checks++;
        if (flick_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b, required 0", flick_pulse); end
        tick(12);
        btn_in = 1'b0;
        tick(6 + HOLD_EXTRA);
        n_checks++;
        if (flick !== 1'b1) begin n_fail++; $display("FAIL release_early: got %b, required 1", flick); end
        tick(1);
        n_checks++;
        if (flick !== 1'b0) begin n_fail++; $display("FAIL release_edge: got %b, required 0", flick); end
        n_checks++;
        if (pulse_seen - p0 != 1) begin n_fail++; $display("FAIL press_pulse_total: got %0d, required 1", pulse_seen - p0); end
    endtask

    task automatic test_press_bounce;
        int p0;
        int r0;
        logic [7:0] pat;
        do_reset();
        p0 = pulse_seen;
        r0 = flick_rises;
        pat = 8'b0111_0111;
        repeat (10) begin
            for (int i = 7; i >= 0; i--) begin
                btn_in = pat[i];
                tick(1);
            end
        end
        btn_in = 1'b0;
        tick(10);
        n_checks++;
        if (flick_rises != r0) begin n_fail++; $display("FAIL bounce_flick: %0d rises, required 0", flick_rises - r0); end
        n_checks++;
        if (pulse_seen != p0) begin n_fail++; $display("FAIL bounce_pulse: %0d pulses, required 0", pulse_seen - p0); end
        n_checks++;
        if (press_count !== 8'd0) begin n_fail++; $display("FAIL bounce_count: got %0d, required 0", press_count); end
    endtask

    task automatic test_release_bounce;
        int p0;
        int f0;
        do_reset();
        btn_in = 1'b1;
        push_press();
        tick(7);
        pop_exp();
        n_checks++;
        if (flick_pulse !== 1'b1 || press_count !== exp_v) begin
            n_fail++;
            $display("FAIL rbounce_press: pulse=%b count=%0d, required pulse=1 count=%0d", flick_pulse, press_count, exp_v);
        end
        tick(5);
        p0 = pulse_seen;
        f0 = flick_falls;
        btn_in = 1'b0;
        tick(2);
        btn_in = 1'b1;
        tick(15);
        n_checks++;
        if (flick !== 1'b1 || flick_falls != f0) begin
            n_fail++;
            $display("FAIL rbounce_flick: flick=%b falls=%0d, required flick=1 falls=0", flick, flick_falls - f0);
        end
        n_checks++;
        if (pulse_seen != p0) begin n_fail++; $display("FAIL rbounce_pulse: %0d extra pulses, required 0", pulse_seen - p0); end
        n_checks++;
        if (press_count !== model_count) begin n_fail++; $display("FAIL rbounce_count: got %0d, required %0d", press_count, model_count); end
        btn_in = 1'b0;
        tick(10 + HOLD_EXTRA);
    endtask

    task automatic test_wrap;
        int p0;
        do_reset();
        p0 = pulse_seen;
        for (int k = 0; k < 256; k++) press_and_check(10, 14);
        n_checks++;
        if (pulse_seen - p0 != 256) begin n_fail++; $display("FAIL wrap_pulses: got %0d, required 256", pulse_seen - p0); end
        n_checks++;
        if (press_count !== 8'd0) begin n_fail++; $display("FAIL wrap_count: got %0d, required 0", press_count); end
    endtask

    task automatic test_mid_reset;
        int p0;
        do_reset();
        press_and_check(10, 14);
        btn_in = 1'b1;
        tick(4);
        rst = 1'b1;
        btn_in = 1'b0;
        tick(1);
        rst = 1'b0;
        model_count = 8'd0;
        exp_q.delete();
        p0 = pulse_seen;
        tick(20);
        n_checks++;
        if (pulse_seen != p0) begin n_fail++; $display("FAIL midrst_pulse: %0d pulses, required 0", pulse_seen - p0); end
        n_checks++;
        if (press_count !== 8'd0 || flick !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: count=%0d flick=%b, required count=0 flick=0", press_count, flick);
        end
    endtask

    task automatic test_repress;
        int f0;
        do_reset();
        btn_in = 1'b1;
        push_press();
        tick(7);
        pop_exp();
        n_checks++;
        if (press_count !== exp_v) begin n_fail++; $display("FAIL repress_first: got %0d, required %0d", press_count, exp_v); end
        tick(5);
        f0 = flick_falls;
        btn_in = 1'b0;
        tick(5);
        btn_in = 1'b1;
        push_press();
        tick(7);
        pop_exp();
        n_checks++;
        if (flick !== 1'b1 || flick_pulse !== 1'b1 || press_count !== exp_v) begin
            n_fail++;
            $display("FAIL repress_second: flick=%b pulse=%b count=%0d, required 1 1 %0d", flick, flick_pulse, press_count, exp_v);
        end
        n_checks++;
        if (flick_falls - f0 != REPRESS_FALLS) begin
            n_fail++;
            $display("FAIL repress_falls: got %0d, required %0d", flick_falls - f0, REPRESS_FALLS);
        end
        btn_in = 1'b0;
        tick(20);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_wrap();
        test_mid_reset();
        test_repress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
